// File: rtl/tff_seq_ctrl_if.sv
// Handshake/control bundle for tff_seq_ctrl.
// master: the requester (drives start/pause/ack/dir/limit, observes status).
// slave : the sequencer itself.
interface tff_seq_ctrl_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic             pause;
   logic             ack;
   logic             dir;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] t_vec;
   logic [1:0]       state;
   logic             busy;
   logic             done;
   logic             tc;

   modport master (
      output start, pause, ack, dir, limit,
      input  count, t_vec, state, busy, done, tc
   );

   modport slave (
      input  start, pause, ack, dir, limit,
      output count, t_vec, state, busy, done, tc
   );
endinterface

// File: rtl/tff_seq_ctrl.sv
// tff_seq_ctrl: start/pause/ack sequencer around a bank of T flip-flops that
// counts up (0 -> limit) or down (limit -> 0).
// Optional feature macro: TFF_SEQ_CTRL_AUTORELOAD_EN -- when defined the
// terminal cycle reloads the start value and stays in RUN instead of DONE.
module tff_seq_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input logic           clk_i,
   input logic           rst_ni,
   tff_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StHold = 2'b10,
      StDone = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] lim_q, lim_d;
   logic             dir_q, dir_d;

   logic [WIDTH-1:0] term_val;
   logic             tc;
   logic             advance;
   logic [WIDTH-1:0] t_vec;

   assign term_val = dir_q ? '0 : lim_q;
   assign tc       = (state_q == StRun) && (count_q == term_val);
   assign advance  = (state_q == StRun) && !tc && !bus.pause;

   // T inputs: ripple-carry style toggle enables, forced to zero unless advancing
   always_comb begin
      logic carry;
      t_vec = '0;
      carry = 1'b1;
      if (advance) begin
         for (int i = 0; i < WIDTH; i++) begin
            t_vec[i] = carry;
            carry    = carry & (dir_q ? ~count_q[i] : count_q[i]);
         end
      end
   end

   // Next-state logic: FSM transitions, capture on start, T-FF toggle otherwise
   always_comb begin
      state_d = state_q;
      count_d = count_q ^ t_vec;
      lim_d   = lim_q;
      dir_d   = dir_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               lim_d   = bus.limit;
               dir_d   = bus.dir;
               count_d = bus.dir ? bus.limit : '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (tc) begin
`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
               count_d = dir_q ? lim_q : '0;
`else
               state_d = StDone;
`endif
            end else if (bus.pause) begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (!bus.pause) state_d = StRun;
         end
         StDone: begin
            if (bus.ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and T-flip-flop bank registers, async active-low reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         count_q <= '0;
         lim_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lim_q   <= lim_d;
         dir_q   <= dir_d;
      end
   end

   assign bus.count = count_q;
   assign bus.t_vec = t_vec;
   assign bus.state = state_q;
   assign bus.busy  = (state_q == StRun) || (state_q == StHold);
   assign bus.done  = (state_q == StDone);
   assign bus.tc    = tc;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed self-checking bench for tff_seq_ctrl (WIDTH=4).
module tb_tff_seq_ctrl;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   tff_seq_ctrl_if #(.WIDTH(4)) ifc ();

   tff_seq_ctrl #(.WIDTH(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      ifc.start = 1'b0;
      ifc.pause = 1'b0;
      ifc.ack   = 1'b0;
      ifc.dir   = 1'b0;
      ifc.limit = 4'd0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      ifc.start = 1'b0;
      ifc.pause = 1'b0;
      ifc.ack   = 1'b0;
      ifc.dir   = 1'b0;
      ifc.limit = 4'd0;
      #12;
      total++;
      if ({ifc.state, ifc.count, ifc.t_vec, ifc.busy, ifc.done, ifc.tc} !== 13'd0) begin
         bad++;
         $display("FAIL reset_outputs: actual st=%b cnt=%b tv=%b b=%b d=%b tc=%b required all 0",
                  ifc.state, ifc.count, ifc.t_vec, ifc.busy, ifc.done, ifc.tc);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_up();
      ifc.limit = 4'd5;
      ifc.dir   = 1'b0;
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      total++;
      if (ifc.state !== 2'b01 || ifc.count !== 4'd0 || ifc.busy !== 1'b1) begin
         bad++;
         $display("FAIL up_start: actual st=%b cnt=%0d busy=%b required 01/0/1",
                  ifc.state, ifc.count, ifc.busy);
      end
      total++;
      if (ifc.t_vec !== 4'b0001) begin
         bad++;
         $display("FAIL up_tvec0: actual=%b required=0001", ifc.t_vec);
      end
      // captured values must not follow later input changes
      ifc.limit = 4'd2;
      ifc.dir   = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         total++;
         if (ifc.count !== 4'(k) || ifc.tc !== (k == 5)) begin
            bad++;
            $display("FAIL up_count_%0d: actual cnt=%0d tc=%b required cnt=%0d tc=%b",
                     k, ifc.count, ifc.tc, k, (k == 5));
         end
      end
      total++;
      if (ifc.t_vec !== 4'b0000) begin
         bad++;
         $display("FAIL up_tvec_term: actual=%b required=0000", ifc.t_vec);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if (ifc.state !== 2'b11 || ifc.done !== 1'b1 || ifc.count !== 4'd5 || ifc.tc !== 1'b0) begin
            bad++;
            $display("FAIL up_done_%0d: actual st=%b done=%b cnt=%0d tc=%b required 11/1/5/0",
                     k, ifc.state, ifc.done, ifc.count, ifc.tc);
         end
      end
      ifc.ack = 1'b1;
      step();
      ifc.ack = 1'b0;
      total++;
      if (ifc.state !== 2'b00 || ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
         bad++;
         $display("FAIL up_ack: actual st=%b done=%b busy=%b required 00/0/0",
                  ifc.state, ifc.done, ifc.busy);
      end
   endtask

   task automatic test_down();
      do_reset();
      ifc.limit = 4'd3;
      ifc.dir   = 1'b1;
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      total++;
      if (ifc.state !== 2'b01 || ifc.count !== 4'd3) begin
         bad++;
         $display("FAIL down_load: actual st=%b cnt=%0d required 01/3", ifc.state, ifc.count);
      end
      step();
      total++;
      if (ifc.count !== 4'd2 || ifc.t_vec !== 4'b0011) begin
         bad++;
         $display("FAIL down_tvec: actual cnt=%0d tv=%b required 2/0011", ifc.count, ifc.t_vec);
      end
      step();
      step();
      total++;
      if (ifc.count !== 4'd0 || ifc.tc !== 1'b1) begin
         bad++;
         $display("FAIL down_term: actual cnt=%0d tc=%b required 0/1", ifc.count, ifc.tc);
      end
      step();
      total++;
      if (ifc.state !== 2'b11 || ifc.done !== 1'b1 || ifc.count !== 4'd0) begin
         bad++;
         $display("FAIL down_done: actual st=%b done=%b cnt=%0d required 11/1/0",
                  ifc.state, ifc.done, ifc.count);
      end
   endtask

   task automatic test_pause_and_async_reset();
      do_reset();
      ifc.limit = 4'd9;
      ifc.dir   = 1'b0;
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      step();
      step();
      ifc.pause = 1'b1;
      #1;
      total++;
      if (ifc.count !== 4'd2 || ifc.t_vec !== 4'b0000) begin
         bad++;
         $display("FAIL pause_tvec: actual cnt=%0d tv=%b required 2/0000", ifc.count, ifc.t_vec);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         total++;
         if (ifc.state !== 2'b10 || ifc.count !== 4'd2 || ifc.busy !== 1'b1 ||
             ifc.t_vec !== 4'b0000) begin
            bad++;
            $display("FAIL hold_%0d: actual st=%b cnt=%0d busy=%b tv=%b required 10/2/1/0000",
                     k, ifc.state, ifc.count, ifc.busy, ifc.t_vec);
         end
      end
      ifc.pause = 1'b0;
      step();
      total++;
      if (ifc.state !== 2'b01 || ifc.count !== 4'd2) begin
         bad++;
         $display("FAIL resume: actual st=%b cnt=%0d required 01/2", ifc.state, ifc.count);
      end
      step();
      total++;
      if (ifc.count !== 4'd3) begin
         bad++;
         $display("FAIL resume_adv: actual cnt=%0d required 3", ifc.count);
      end
      step();
      step();
      step();
      total++;
      if (ifc.count !== 4'd6 || ifc.state !== 2'b01) begin
         bad++;
         $display("FAIL pre_reset: actual cnt=%0d st=%b required 6/01", ifc.count, ifc.state);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (ifc.count !== 4'd0 || ifc.state !== 2'b00 || ifc.busy !== 1'b0 ||
          ifc.tc !== 1'b0 || ifc.t_vec !== 4'b0000) begin
         bad++;
         $display("FAIL async_reset: actual cnt=%0d st=%b busy=%b tc=%b tv=%b required 0/00/0/0/0",
                  ifc.count, ifc.state, ifc.busy, ifc.tc, ifc.t_vec);
      end
      // first edge after release samples start
      #1;
      rst_n     = 1'b1;
      ifc.limit = 4'd4;
      ifc.dir   = 1'b1;
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      total++;
      if (ifc.state !== 2'b01 || ifc.count !== 4'd4) begin
         bad++;
         $display("FAIL post_reset_start: actual st=%b cnt=%0d required 01/4",
                  ifc.state, ifc.count);
      end
   endtask

   task automatic test_limit_zero();
      do_reset();
      ifc.limit = 4'd0;
      ifc.dir   = 1'b0;
      ifc.start = 1'b1;
      step();
      total++;
      if (ifc.state !== 2'b01 || ifc.count !== 4'd0 || ifc.tc !== 1'b1 || ifc.t_vec !== 4'd0) begin
         bad++;
         $display("FAIL lim0_run: actual st=%b cnt=%0d tc=%b tv=%b required 01/0/1/0000",
                  ifc.state, ifc.count, ifc.tc, ifc.t_vec);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if (ifc.state !== 2'b11 || ifc.done !== 1'b1 || ifc.count !== 4'd0 || ifc.tc !== 1'b0) begin
            bad++;
            $display("FAIL lim0_done_%0d: actual st=%b done=%b cnt=%0d tc=%b required 11/1/0/0",
                     k, ifc.state, ifc.done, ifc.count, ifc.tc);
         end
      end
      ifc.start = 1'b0;
   endtask

   task automatic test_full_range();
      do_reset();
      ifc.limit = 4'd15;
      ifc.dir   = 1'b0;
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      for (int k = 0; k < 15; k++) step();
      total++;
      if (ifc.count !== 4'd15 || ifc.tc !== 1'b1) begin
         bad++;
         $display("FAIL full_term: actual cnt=%0d tc=%b required 15/1", ifc.count, ifc.tc);
      end
      step();
      total++;
      if (ifc.count !== 4'd15 || ifc.done !== 1'b1) begin
         bad++;
         $display("FAIL full_nowrap: actual cnt=%0d done=%b required 15/1", ifc.count, ifc.done);
      end
   endtask

   task automatic test_autoreload();
      do_reset();
      ifc.limit = 4'd2;
      ifc.dir   = 1'b0;
      ifc.start = 1'b1;
      step();
      ifc.start = 1'b0;
      ifc.ack   = 1'b1;
      for (int k = 0; k < 7; k++) begin
         total++;
         if (ifc.count !== 4'(k % 3) || ifc.tc !== ((k % 3) == 2) || ifc.done !== 1'b0 ||
             ifc.state !== 2'b01) begin
            bad++;
            $display("FAIL reload_%0d: actual cnt=%0d tc=%b done=%b st=%b required cnt=%0d tc=%b 0 01",
                     k, ifc.count, ifc.tc, ifc.done, ifc.state, k % 3, ((k % 3) == 2));
         end
         step();
      end
      ifc.ack = 1'b0;
   endtask

   initial begin
      test_reset();
`ifdef TFF_SEQ_CTRL_AUTORELOAD_EN
      test_autoreload();
`else
      test_up();
      test_down();
      test_pause_and_async_reset();
      test_limit_zero();
      test_full_range();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
